// File: rtl/wb_stage_pipe_if.sv
// MEM -> WB instruction handshake bundle: MEM presents an instruction with
// mem_valid, WB answers with wb_allowin, transfer when both are high.
interface wb_stage_pipe_if #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
);
  localparam int OFFW = $clog2(XLEN / 8);

  logic                mem_valid;
  logic                wb_allowin;
  logic [XLEN-1:0]     mem_pc;
  logic [XLEN-1:0]     mem_calc;
  logic [2*XLEN-1:0]   mem_mul;
  logic [1:0]          mem_mul_sel;
  logic [RADDR-1:0]    mem_dest;
  logic                mem_gr_we;
  logic                mem_ld;
  logic [1:0]          mem_ld_size;
  logic                mem_ld_signed;
  logic [OFFW-1:0]     mem_ld_off;

  // MEM stage side
  modport master (
    output mem_valid, mem_pc, mem_calc, mem_mul, mem_mul_sel, mem_dest,
           mem_gr_we, mem_ld, mem_ld_size, mem_ld_signed, mem_ld_off,
    input  wb_allowin
  );

  // WB stage side
  modport slave (
    input  mem_valid, mem_pc, mem_calc, mem_mul, mem_mul_sel, mem_dest,
           mem_gr_we, mem_ld, mem_ld_size, mem_ld_signed, mem_ld_off,
    output wb_allowin
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// Writeback stage: holds one instruction, waits for load data when needed,
// extracts/extends sub-word loads, drives the register-file write port,
// exports forwarding info and counts retired instructions.
module wb_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  wb_stage_pipe_if.slave      mem,
  input  logic                data_ok,
  input  logic [XLEN-1:0]     data_rdata,
  input  logic                flush,
  output logic                rf_we,
  output logic [RADDR-1:0]    rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic                fwd_valid,
  output logic                fwd_pend,
  output logic [RADDR-1:0]    fwd_dest,
  output logic [XLEN-1:0]     fwd_data,
  output logic [CNT_W-1:0]    retire_cnt,
  output logic [XLEN-1:0]     debug_wb_pc,
  output logic [XLEN/8-1:0]   debug_wb_rf_we,
  output logic [RADDR-1:0]    debug_wb_rf_wnum,
  output logic [XLEN-1:0]     debug_wb_rf_wdata
);
  localparam int OFFW = $clog2(XLEN / 8);

  // EMPTY: nothing held; WAIT: load awaiting data; READY: result available
  // (commits this cycle); DRAIN: flushed load whose response is still due.
  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY, S_DRAIN} state_t;

  state_t            state;
  logic [XLEN-1:0]   wb_pc;
  logic [RADDR-1:0]  wb_dest;
  logic              wb_gr_we;
  logic [1:0]        wb_ld_size;
  logic              wb_ld_signed;
  logic [OFFW-1:0]   wb_ld_off;
  logic [XLEN-1:0]   wb_result;

  logic              accept;
  logic              commit;
  logic [XLEN-1:0]   sel_result;

  logic [OFFW-1:0]   eff_off;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   keep_mask;
  logic              sign_bit;
  int                ext_w;
  logic [XLEN-1:0]   ld_value;

  // Acceptance never looks at mem_valid, so there is no valid->allowin loop.
  assign mem.wb_allowin = ((state == S_EMPTY) || (state == S_READY)) && !flush;
  assign accept         = mem.mem_valid && mem.wb_allowin;
  assign commit         = (state == S_READY) && !flush;

  // Pick ALU result or one half of the full multiplier product.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel_result = mem.mem_calc;
    case (mem.mem_mul_sel)
      2'b01:   sel_result = mem.mem_mul[XLEN-1:0];
      2'b10:   sel_result = mem.mem_mul[2*XLEN-1:XLEN];
      default: sel_result = mem.mem_calc;
    endcase
  end

  // Align the response to the access size, shift the field down and extend it.
  always_comb begin
    eff_off  = wb_ld_off;
    ext_w    = XLEN;
    sign_bit = 1'b0;
    case (wb_ld_size)
      2'd0:    ext_w = 8;
      2'd1:    begin eff_off[0]   = 1'b0;  ext_w = 16; end
      2'd2:    begin eff_off[1:0] = 2'b00; ext_w = 32; end
      default: begin eff_off      = '0;    ext_w = XLEN; end
    endcase
    shifted = data_rdata >> {eff_off, 3'b000};
    case (wb_ld_size)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[XLEN-1];
    endcase
    // Shifting all-ones by the full width leaves zero, so a full-width access keeps everything.
    keep_mask = ~({XLEN{1'b1}} << ext_w);
    ld_value  = (shifted & keep_mask) | ({XLEN{wb_ld_signed & sign_bit}} & ~keep_mask);
  end

  // Stage FSM, captured instruction fields, result register and retire counter.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!resetn) begin
      state        <= S_EMPTY;
      wb_pc        <= '0;
      wb_dest      <= '0;
      wb_gr_we     <= 1'b0;
      wb_ld_size   <= '0;
      wb_ld_signed <= 1'b0;
      wb_ld_off    <= '0;
      wb_result    <= '0;
      retire_cnt   <= '0;
    end else begin
      if (commit) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
      if (accept) begin
        wb_pc        <= mem.mem_pc;
        wb_dest      <= mem.mem_dest;
        wb_gr_we     <= mem.mem_gr_we;
        wb_ld_size   <= mem.mem_ld_size;
        wb_ld_signed <= mem.mem_ld_signed;
        wb_ld_off    <= mem.mem_ld_off;
        wb_result    <= sel_result;
        state        <= mem.mem_ld ? S_WAIT : S_READY;
      end else begin
        case (state)
          S_EMPTY: state <= S_EMPTY;
          S_READY: state <= S_EMPTY;
          S_WAIT: begin
            if (flush) begin
              // A response arriving together with the flush is simply dropped.
              state <= data_ok ? S_EMPTY : S_DRAIN;
            end else if (data_ok) begin
              wb_result <= ld_value;
              state     <= S_READY;
            end
          end
          S_DRAIN: if (data_ok) state <= S_EMPTY;
          default: state <= S_EMPTY;
        endcase
      end
    end
  end

  assign rf_we     = (state == S_READY) && wb_gr_we && !flush;
  assign rf_waddr  = wb_dest;
  assign rf_wdata  = wb_result;

  assign fwd_valid = ((state == S_WAIT) || (state == S_READY)) && wb_gr_we && (wb_dest != '0);
  assign fwd_pend  = fwd_valid && (state == S_WAIT);
  assign fwd_dest  = wb_dest;
  assign fwd_data  = wb_result;

  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_we    = {(XLEN/8){rf_we}};
  assign debug_wb_rf_wnum  = wb_dest;
  assign debug_wb_rf_wdata = wb_result;
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: directed scenarios plus random traffic on an
// XLEN=32 instance checked against a transaction-level model, and a directed
// XLEN=64 / CNT_W=4 instance for dword loads and counter wrap.
module tb_wb_stage_pipe;
  logic clk;
  logic resetn;

  // ---------------- XLEN = 32 instance ----------------
  wb_stage_pipe_if #(.XLEN(32), .RADDR(5)) bus32 ();
  logic        data_ok;
  logic [31:0] data_rdata;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic        fwd_pend;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic [31:0] retire_cnt;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  wb_stage_pipe #(.XLEN(32), .RADDR(5), .CNT_W(32)) dut32 (
    .clk(clk), .resetn(resetn), .mem(bus32),
    .data_ok(data_ok), .data_rdata(data_rdata), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_pend(fwd_pend), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // ---------------- XLEN = 64, CNT_W = 4 instance ----------------
  wb_stage_pipe_if #(.XLEN(64), .RADDR(5)) bus64 ();
  logic        data_ok64;
  logic [63:0] data_rdata64;
  logic        flush64;
  logic        rf_we64;
  logic [4:0]  rf_waddr64;
  logic [63:0] rf_wdata64;
  logic        fwd_valid64;
  logic        fwd_pend64;
  logic [4:0]  fwd_dest64;
  logic [63:0] fwd_data64;
  logic [3:0]  retire_cnt64;
  logic [63:0] debug_wb_pc64;
  logic [7:0]  debug_wb_rf_we64;
  logic [4:0]  debug_wb_rf_wnum64;
  logic [63:0] debug_wb_rf_wdata64;

  wb_stage_pipe #(.XLEN(64), .RADDR(5), .CNT_W(4)) dut64 (
    .clk(clk), .resetn(resetn), .mem(bus64),
    .data_ok(data_ok64), .data_rdata(data_rdata64), .flush(flush64),
    .rf_we(rf_we64), .rf_waddr(rf_waddr64), .rf_wdata(rf_wdata64),
    .fwd_valid(fwd_valid64), .fwd_pend(fwd_pend64), .fwd_dest(fwd_dest64), .fwd_data(fwd_data64),
    .retire_cnt(retire_cnt64), .debug_wb_pc(debug_wb_pc64), .debug_wb_rf_we(debug_wb_rf_we64),
    .debug_wb_rf_wnum(debug_wb_rf_wnum64), .debug_wb_rf_wdata(debug_wb_rf_wdata64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Load result from the access rules: aligned field of 1/2/4/8 bytes, extended.
  function automatic logic [63:0] ref_load(input int xlen, input logic [63:0] data,
                                           input int size, input bit sgn, input int off);
    int nbytes;
    int base;
    logic [63:0] field;
    logic [63:0] mask;
    case (size)
      0:       nbytes = 1;
      1:       nbytes = 2;
      2:       nbytes = 4;
      default: nbytes = (xlen == 64) ? 8 : 4;
    endcase
    base  = (off / nbytes) * nbytes;
    field = data >> (8 * base);
    mask  = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
    field = field & mask;
    if (sgn && field[8 * nbytes - 1]) field = field | ~mask;
    if (xlen == 32) field[63:32] = '0;
    return field;
  endfunction

  // Transaction-level model of the 32-bit instance: one held instruction
  // slot, whether its result is known, and an orphaned load response.
  bit          s_valid, s_data, orphan;
  logic [31:0] s_pc, s_val;
  logic [4:0]  s_dest;
  bit          s_we, s_sgn;
  int          s_size, s_off;
  logic [31:0] exp_cnt;

  // One cycle of the 32-bit instance: inputs are already applied.
  task automatic tick();
    bit exp_allow, exp_we, exp_fv, acc;
    logic [63:0] lv;
    #1;
    exp_allow = !(s_valid && !s_data) && !orphan && !flush;
    exp_we    = s_valid && s_data && s_we && !flush;
    exp_fv    = s_valid && s_we && (s_dest != 5'd0);
    check("allowin",   bus32.wb_allowin, exp_allow);
    check("rf_we",     rf_we, exp_we);
    check("dbg_we",    debug_wb_rf_we, {4{exp_we}});
    check("fwd_valid", fwd_valid, exp_fv);
    check("fwd_pend",  fwd_pend, exp_fv && !s_data);
    check("retire",    retire_cnt, exp_cnt);
    if (exp_fv) check("fwd_dest", fwd_dest, s_dest);
    if (exp_fv && s_data) check("fwd_data", fwd_data, s_val);
    if (exp_we) begin
      check("waddr",    rf_waddr, s_dest);
      check("wdata",    rf_wdata, s_val);
      check("dbg_pc",   debug_wb_pc, s_pc);
      check("dbg_wnum", debug_wb_rf_wnum, s_dest);
      check("dbg_wdat", debug_wb_rf_wdata, s_val);
    end
    // Advance the model across the coming edge.
    if (s_valid && s_data && !flush) exp_cnt++;
    acc = bus32.mem_valid && exp_allow;
    if (orphan) begin
      if (data_ok) orphan = 0;
    end else if (s_valid && !s_data) begin
      if (flush) begin
        s_valid = 0;
        orphan  = !data_ok;
      end else if (data_ok) begin
        lv     = ref_load(32, {32'd0, data_rdata}, s_size, s_sgn, s_off);
        s_val  = lv[31:0];
        s_data = 1;
      end
    end else if (acc) begin
      s_valid = 1;
      s_data  = !bus32.mem_ld;
      s_pc    = bus32.mem_pc;
      s_dest  = bus32.mem_dest;
      s_we    = bus32.mem_gr_we;
      s_size  = int'(bus32.mem_ld_size);
      s_sgn   = bus32.mem_ld_signed;
      s_off   = int'(bus32.mem_ld_off);
      case (bus32.mem_mul_sel)
        2'b01:   s_val = bus32.mem_mul[31:0];
        2'b10:   s_val = bus32.mem_mul[63:32];
        default: s_val = bus32.mem_calc;
      endcase
    end else begin
      s_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_op(input logic [31:0] pc, input logic [31:0] calc, input logic [63:0] mul,
                        input logic [1:0] sel, input logic [4:0] dest, input bit we, input bit ld,
                        input logic [1:0] size, input bit sgn, input logic [1:0] off);
    bus32.mem_valid     = 1'b1;
    bus32.mem_pc        = pc;
    bus32.mem_calc      = calc;
    bus32.mem_mul       = mul;
    bus32.mem_mul_sel   = sel;
    bus32.mem_dest      = dest;
    bus32.mem_gr_we     = we;
    bus32.mem_ld        = ld;
    bus32.mem_ld_size   = size;
    bus32.mem_ld_signed = sgn;
    bus32.mem_ld_off    = off;
  endtask

  task automatic idle();
    bus32.mem_valid = 1'b0;
    flush           = 1'b0;
    data_ok         = 1'b0;
  endtask

  task automatic rand_inputs();
    set_op($urandom, $urandom, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    bus32.mem_valid = ($urandom_range(0, 9) < 7);
    flush           = ($urandom_range(0, 9) == 0);
    // Responses only while a load (live or flushed) is outstanding.
    data_ok         = ((s_valid && !s_data) || orphan) && ($urandom_range(0, 2) == 0);
    data_rdata      = $urandom;
  endtask

  task automatic set64(input bit valid, input logic [63:0] calc, input bit ld,
                       input logic [1:0] size, input bit sgn, input logic [2:0] off);
    bus64.mem_valid     = valid;
    bus64.mem_pc        = 64'h1000 + calc;
    bus64.mem_calc      = calc;
    bus64.mem_mul       = '0;
    bus64.mem_mul_sel   = 2'b00;
    bus64.mem_dest      = 5'd3;
    bus64.mem_gr_we     = 1'b1;
    bus64.mem_ld        = ld;
    bus64.mem_ld_size   = size;
    bus64.mem_ld_signed = sgn;
    bus64.mem_ld_off    = off;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    set_op('0, '0, '0, 2'b00, 5'd0, 0, 0, 2'd0, 0, 2'd0);
    idle();
    data_rdata = '0;
    set64(0, '0, 0, 2'd0, 0, 3'd0);
    data_ok64 = 1'b0; data_rdata64 = '0; flush64 = 1'b0;
    s_valid = 0; s_data = 0; orphan = 0; exp_cnt = '0;
    s_pc = '0; s_val = '0; s_dest = '0; s_we = 0; s_sgn = 0; s_size = 0; s_off = 0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_rf_we",   rf_we, 1'b0);
    check("rst_retire",  retire_cnt, 32'd0);
    check("rst_allowin", bus32.wb_allowin, 1'b1);
    check("rst_fwd",     fwd_valid, 1'b0);
    check("rst_wdata",   rf_wdata, 32'd0);
    check("rst_pc",      debug_wb_pc, 32'd0);
    check("rst64_cnt",   retire_cnt64, 4'd0);
    check("rst64_allow", bus64.wb_allowin, 1'b1);
    resetn = 1'b1;
    @(negedge clk);

    // Single ALU op
    set_op(32'h100, 32'h1234, '0, 2'b00, 5'd5, 1, 0, 2'd0, 0, 2'd0);
    tick();
    idle();
    #1;
    check("alu_we",    rf_we, 1'b1);
    check("alu_waddr", rf_waddr, 5'd5);
    check("alu_wdata", rf_wdata, 32'h1234);
    tick();
    #1 check("alu_retire", retire_cnt, 32'd1);

    // Back-to-back multiplier halves
    for (int i = 0; i < 4; i++) begin
      set_op(32'h200 + i, '0, 64'hFFFF_FFFE_0000_0003, (i % 2 == 0) ? 2'b01 : 2'b10,
             5'(i + 1), 1, 0, 2'd0, 0, 2'd0);
      if (i > 0) begin
        #1;
        check("b2b_we", rf_we, 1'b1);
        check("b2b_wdata", rf_wdata, (i % 2 == 1) ? 32'h0000_0003 : 32'hFFFF_FFFE);
      end
      tick();
    end
    idle();
    #1;
    check("b2b_last", rf_wdata, 32'hFFFF_FFFE);
    tick();

    // Load stall: lb signed off 3, then lhu off 2
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_op(32'h300, '0, '0, 2'b00, 5'd7, 1, 1, 2'd0, 1, 2'd3);
      else        set_op(32'h304, '0, '0, 2'b00, 5'd8, 1, 1, 2'd1, 0, 2'd2);
      tick();
      idle();
      for (int w = 0; w < 3; w++) begin
        #1;
        check("ld_wait_allow", bus32.wb_allowin, 1'b0);
        check("ld_wait_pend",  fwd_pend, 1'b1);
        tick();
      end
      data_ok = 1'b1; data_rdata = 32'h80AB_CDEF;
      tick();
      idle();
      #1;
      check("ld_we", rf_we, 1'b1);
      check("ld_wdata", rf_wdata, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_80AB);
      tick();
    end

    // Flush while waiting for load data
    set_op(32'h400, '0, '0, 2'b00, 5'd9, 1, 1, 2'd2, 0, 2'd0);
    tick();
    idle(); flush = 1'b1;
    tick();
    idle();
    #1 check("drain_allow0", bus32.wb_allowin, 1'b0);
    tick();
    data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1 check("drain_allow1", bus32.wb_allowin, 1'b0);
    tick();
    idle();
    #1;
    check("drain_done", bus32.wb_allowin, 1'b1);
    check("drain_nowe", rf_we, 1'b0);
    check("drain_cnt",  retire_cnt, 32'd7);
    tick();

    // Flush in READY together with a new instruction
    set_op(32'h500, 32'h55, '0, 2'b00, 5'd10, 1, 0, 2'd0, 0, 2'd0);
    tick();
    set_op(32'h504, 32'h66, '0, 2'b00, 5'd11, 1, 0, 2'd0, 0, 2'd0);
    flush = 1'b1;
    #1;
    check("fr_nowe",  rf_we, 1'b0);
    check("fr_allow", bus32.wb_allowin, 1'b0);
    tick();
    idle();
    #1;
    check("fr_empty", fwd_valid, 1'b0);
    check("fr_cnt",   retire_cnt, 32'd7);
    tick();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      tick();
    end
    idle();
    repeat (4) tick();

    // XLEN=64: ld dword, then lw signed off 4
    set64(1, '0, 1, 2'd3, 0, 3'd0);
    @(negedge clk);
    bus64.mem_valid = 1'b0;
    @(negedge clk);
    data_ok64 = 1'b1; data_rdata64 = 64'h8000_0000_0000_0001;
    @(negedge clk);
    data_ok64 = 1'b0;
    #1;
    check("x64_ld_we",    rf_we64, 1'b1);
    check("x64_ld",       rf_wdata64, 64'h8000_0000_0000_0001);
    check("x64_dbg_we",   debug_wb_rf_we64, 8'hFF);
    set64(1, '0, 1, 2'd2, 1, 3'd4);
    @(negedge clk);
    bus64.mem_valid = 1'b0;
    data_ok64 = 1'b1;
    @(negedge clk);
    data_ok64 = 1'b0;
    #1;
    check("x64_lw_we", rf_we64, 1'b1);
    check("x64_lw",    rf_wdata64, 64'hFFFF_FFFF_8000_0000);
    @(negedge clk);
    #1 check("x64_cnt2", retire_cnt64, 4'd2);
    for (int i = 0; i < 15; i++) begin
      set64(1, 64'(i), 0, 2'd0, 0, 3'd0);
      @(negedge clk);
    end
    bus64.mem_valid = 1'b0;
    @(negedge clk);
    #1;
    check("x64_wrap",   retire_cnt64, 4'd1);
    check("x64_idle",   rf_we64, 1'b0);
    check("x64_allow",  bus64.wb_allowin, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
